// File: rtl/spi_controller.sv
// SPI mode-0 initiator: turns one valid/ready register request into a 16-bit
// frame {rw, addr[6:0], data[7:0]} and returns the read byte captured from cipo.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sclk,
    output logic       copi,
    input  logic       cipo,
    output logic       ncs
);

    localparam int unsigned HW = 8;
    localparam int unsigned BW = 4;
    localparam int unsigned FW = 16;
    localparam logic [HW-1:0] H_RELOAD = HW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic          high, high_nxt;
    logic [FW-1:0] shreg, shreg_nxt;
    logic          is_read, is_read_nxt;
    logic [7:0]    cap, cap_nxt;
    logic          sync1, sync2;
    logic          sclk_nxt, copi_nxt, ncs_nxt, done_nxt;
    logic [7:0]    rd_nxt;
    logic [FW-1:0] frame_c;

    assign req_ready = (state == IDLE);
    assign frame_c   = {req_write, req_addr, req_write ? req_wdata : 8'h00};

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_cnt   <= '0;
            bit_cnt <= '0;
            high    <= 1'b0;
            shreg   <= '0;
            is_read <= 1'b0;
            cap     <= '0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            ncs     <= 1'b1;
            done    <= 1'b0;
            rd_data <= '0;
        end else begin
            state   <= state_nxt;
            h_cnt   <= h_nxt;
            bit_cnt <= bit_nxt;
            high    <= high_nxt;
            shreg   <= shreg_nxt;
            is_read <= is_read_nxt;
            cap     <= cap_nxt;
            sync1   <= cipo;
            sync2   <= sync1;
            sclk    <= sclk_nxt;
            copi    <= copi_nxt;
            ncs     <= ncs_nxt;
            done    <= done_nxt;
            rd_data <= rd_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        h_nxt       = h_cnt;
        bit_nxt     = bit_cnt;
        high_nxt    = high;
        shreg_nxt   = shreg;
        is_read_nxt = is_read;
        cap_nxt     = cap;
        sclk_nxt    = sclk;
        copi_nxt    = copi;
        ncs_nxt     = ncs;
        done_nxt    = 1'b0;
        rd_nxt      = rd_data;

        case (state)
            IDLE: begin
                sclk_nxt = 1'b0;
                ncs_nxt  = 1'b1;
                copi_nxt = 1'b0;
                if (req_valid) begin
                    state_nxt   = SHIFT;
                    shreg_nxt   = frame_c;
                    is_read_nxt = ~req_write;
                    copi_nxt    = frame_c[FW-1];
                    ncs_nxt     = 1'b0;
                    h_nxt       = H_RELOAD;
                    bit_nxt     = BW'(FW - 1);
                    high_nxt    = 1'b0;
                end
            end
            SHIFT: begin
                if (h_cnt != '0) begin
                    h_nxt = h_cnt - HW'(1);
                end else if (!high) begin
                    h_nxt    = H_RELOAD;
                    high_nxt = 1'b1;
                    sclk_nxt = 1'b1;
                end else begin
                    // End of high half: sample just before sclk falls
                    h_nxt    = H_RELOAD;
                    high_nxt = 1'b0;
                    sclk_nxt = 1'b0;
                    cap_nxt  = {cap[6:0], sync2};
                    if (bit_cnt == '0) begin
                        state_nxt = HOLD;
                    end else begin
                        bit_nxt   = bit_cnt - BW'(1);
                        shreg_nxt = {shreg[FW-2:0], 1'b0};
                        copi_nxt  = shreg[FW-2];
                    end
                end
            end
            HOLD: begin
                if (h_cnt != '0) begin
                    h_nxt = h_cnt - HW'(1);
                end else begin
                    state_nxt = GAP;
                    h_nxt     = H_RELOAD;
                    ncs_nxt   = 1'b1;
                    copi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    if (is_read) begin
                        rd_nxt = cap;
                    end
                end
            end
            GAP: begin
                if (h_cnt != '0) begin
                    h_nxt = h_cnt - HW'(1);
                end else begin
                    state_nxt = IDLE;
                    h_nxt     = H_RELOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
